// File: rtl/hdmi_sched_pkg.sv
// Shared encodings for the HDMI source scheduler: source select, FSM states
// and the menu code that selects the oscilloscope.
package hdmi_sched_pkg;

  localparam logic SRC_GEN = 1'b0;
  localparam logic SRC_OSC = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUTE_OLD = 2'd1,
    MUTE_NEW = 2'd2
  } sched_state_t;

  localparam logic [2:0] OSC_CODE_DFLT = 3'b101;

endpackage

// File: rtl/frame_tick_gen.sv
// Rising-edge detector for a vsync input; emits a registered one-cycle frame tick.
// History resets high so a vsync already asserted at reset release is not a frame start.
module frame_tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic vs,
  output logic tick
);

  logic vs_prev_reg;
  logic tick_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_prev_reg <= 1'b1;
      tick_reg    <= 1'b0;
    end else begin
      vs_prev_reg <= vs;
      tick_reg    <= vs & ~vs_prev_reg;
    end
  end

  assign tick = tick_reg;

endmodule

// File: rtl/hdmi_src_sched.sv
// Frame-synchronous selector between the sig-gen and oscilloscope video streams.
// Source swaps are hidden behind black frames; also arms the wave capture per frame.
module hdmi_src_sched
  import hdmi_sched_pkg::*;
#(
  parameter int          BLANK_FRAMES  = 2,
  parameter int          STABLE_FRAMES = 1,
  parameter logic [2:0]  OSC_CODE      = OSC_CODE_DFLT
) (
  input  logic        pix_clk,
  input  logic        rst,
  input  logic        level,
  input  logic [1:0]  cnt_level1,
  input  logic        gen_vs,
  input  logic        gen_hs,
  input  logic        gen_de,
  input  logic [23:0] gen_rgb,
  input  logic        osc_vs,
  input  logic        osc_hs,
  input  logic        osc_de,
  input  logic [23:0] osc_rgb,
  output logic        vs_out,
  output logic        hs_out,
  output logic        de_out,
  output logic [23:0] rgb_out,
  output logic        cur_src,
  output logic        busy,
  output logic        cap_arm
);

  generate
    if (BLANK_FRAMES < 1 || BLANK_FRAMES > 15) begin : g_bad_blank
      $error("hdmi_src_sched: BLANK_FRAMES must be within 1..15");
    end
    if (STABLE_FRAMES < 1 || STABLE_FRAMES > 15) begin : g_bad_stable
      $error("hdmi_src_sched: STABLE_FRAMES must be within 1..15");
    end
  endgenerate

  localparam logic [3:0] BLANK_LIM  = 4'(BLANK_FRAMES);
  localparam logic [3:0] STABLE_LIM = 4'(STABLE_FRAMES);

  logic         tick;
  logic         want;
  sched_state_t state_reg;
  logic         cur_src_reg;
  logic [3:0]   stable_cnt_reg;
  logic [3:0]   mute_cnt_reg;
  logic         busy_reg;
  logic         cap_arm_reg;

  logic         sel_vs, sel_hs, sel_de;
  logic [23:0]  sel_rgb;
  logic         vs_out_reg, hs_out_reg, de_out_reg;
  logic [23:0]  rgb_out_reg;

  frame_tick_gen u_tick (
    .clk  (pix_clk),
    .rst  (rst),
    .vs   (gen_vs),
    .tick (tick)
  );

  assign want = ({level, cnt_level1} == OSC_CODE);

  // Requests are only looked at on frame ticks; mid-switch changes are ignored.
  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cur_src_reg    <= SRC_GEN;
      stable_cnt_reg <= 4'd0;
      mute_cnt_reg   <= 4'd0;
      busy_reg       <= 1'b0;
      cap_arm_reg    <= 1'b0;
    end else begin
      cap_arm_reg <= 1'b0;
      if (tick) begin
        unique case (state_reg)
          IDLE: begin
            cap_arm_reg <= (cur_src_reg == SRC_OSC);
            if (want != cur_src_reg) begin
              if (stable_cnt_reg + 4'd1 == STABLE_LIM) begin
                stable_cnt_reg <= 4'd0;
                state_reg      <= MUTE_OLD;
                busy_reg       <= 1'b1;
              end else begin
                stable_cnt_reg <= stable_cnt_reg + 4'd1;
              end
            end else begin
              stable_cnt_reg <= 4'd0;
            end
          end
          MUTE_OLD: begin
            cur_src_reg  <= ~cur_src_reg;
            mute_cnt_reg <= BLANK_LIM;
            state_reg    <= MUTE_NEW;
          end
          MUTE_NEW: begin
            if (mute_cnt_reg == 4'd1) begin
              mute_cnt_reg <= 4'd0;
              state_reg    <= IDLE;
              busy_reg     <= 1'b0;
              cap_arm_reg  <= (cur_src_reg == SRC_OSC);
            end else begin
              mute_cnt_reg <= mute_cnt_reg - 4'd1;
            end
          end
          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    sel_vs  = gen_vs;
    sel_hs  = gen_hs;
    sel_de  = gen_de;
    sel_rgb = gen_rgb;
    if (cur_src_reg == SRC_OSC) begin
      sel_vs  = osc_vs;
      sel_hs  = osc_hs;
      sel_de  = osc_de;
      sel_rgb = osc_rgb;
    end
  end

  // Timing always follows the selected source; pixels are blacked out mid-switch.
  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      vs_out_reg  <= 1'b0;
      hs_out_reg  <= 1'b0;
      de_out_reg  <= 1'b0;
      rgb_out_reg <= 24'd0;
    end else begin
      vs_out_reg  <= sel_vs;
      hs_out_reg  <= sel_hs;
      de_out_reg  <= sel_de;
      rgb_out_reg <= (state_reg == IDLE) ? sel_rgb : 24'd0;
    end
  end

  assign vs_out  = vs_out_reg;
  assign hs_out  = hs_out_reg;
  assign de_out  = de_out_reg;
  assign rgb_out = rgb_out_reg;
  assign cur_src = cur_src_reg;
  assign busy    = busy_reg;
  assign cap_arm = cap_arm_reg;

endmodule
